muldiv_controller: RTL and testbench



---
 rtl/muldiv_pkg.sv | 40 ++++
 rtl/muldiv_datapath.sv | 102 ++++++++++
 rtl/muldiv_controller.sv | 114 +++++++++++
 tb/tb_muldiv_controller.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op encodings, FSM states, widths and op-class predicates
// shared by the RV32M multiply/divide sequencer.
package muldiv_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned ITER_LAST = 31;
    localparam int unsigned CNT_W     = 5;
    localparam int unsigned OP_W      = 3;
    localparam int unsigned RD_W      = 5;

    typedef enum logic [OP_W-1:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } mdOp_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mdState_t;

    function automatic logic is_div(input logic [OP_W-1:0] op);
        return op[2];
    endfunction

    function automatic logic is_signed_a(input logic [OP_W-1:0] op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_signed_b(input logic [OP_W-1:0] op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// muldiv_datapath: shared hi/lo shift registers for the 32-step shift-add
// multiply and restoring divide, with magnitude conditioning and sign fix-up.
module muldiv_datapath
    import muldiv_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic            load,
    input  logic            step,
    input  logic [OP_W-1:0] op,
    input  logic [XLEN-1:0] srcA,
    input  logic [XLEN-1:0] srcB,
    output logic [XLEN-1:0] result_c
);

    logic [XLEN-1:0]   hiReg;
    logic [XLEN-1:0]   loReg;
    logic [XLEN-1:0]   operandReg;
    logic [OP_W-1:0]   opReg;
    logic              negResult;
    logic              holdReg;

    logic              signA;
    logic              signB;
    logic              divZero;
    logic [XLEN-1:0]   magA;
    logic [XLEN-1:0]   magB;
    logic [XLEN:0]     mulSum;
    logic [XLEN:0]     divDiff;
    logic [XLEN-1:0]   hiNext;
    logic [XLEN-1:0]   loNext;
    logic [2*XLEN-1:0] product;
    logic [2*XLEN-1:0] productFix;
    logic [XLEN-1:0]   divRaw;

    // Operand magnitudes and signs, evaluated on the accept cycle.
    always_comb begin
        signA   = is_signed_a(op) & srcA[XLEN-1];
        signB   = is_signed_b(op) & srcB[XLEN-1];
        magA    = signA ? (~srcA + XLEN'(1)) : srcA;
        magB    = signB ? (~srcB + XLEN'(1)) : srcB;
        divZero = (srcB == '0);
    end

    // One iteration: hi accumulates the product / holds the partial remainder.
    always_comb begin
        mulSum  = {1'b0, hiReg} + {1'b0, (loReg[0] ? operandReg : XLEN'(0))};
        divDiff = {hiReg, loReg[XLEN-1]} - {1'b0, operandReg};
        hiNext  = hiReg;
        loNext  = loReg;
        if (is_div(opReg)) begin
            hiNext = divDiff[XLEN] ? {hiReg[XLEN-2:0], loReg[XLEN-1]} : divDiff[XLEN-1:0];
            loNext = {loReg[XLEN-2:0], ~divDiff[XLEN]};
        end else begin
            hiNext = mulSum[XLEN:1];
            loNext = {mulSum[0], loReg[XLEN-1:1]};
        end
    end

    // A zero divisor preloads the architectural answer and freezes the registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            hiReg      <= '0;
            loReg      <= '0;
            operandReg <= '0;
            opReg      <= '0;
            negResult  <= 1'b0;
            holdReg    <= 1'b0;
        end else if (load) begin
            opReg   <= op;
            holdReg <= is_div(op) & divZero;
            if (is_div(op)) begin
                operandReg <= magB;
                hiReg      <= divZero ? magA : '0;
                loReg      <= divZero ? '1 : magA;
                negResult  <= op[1] ? signA : ((signA ^ signB) & ~divZero);
            end else begin
                operandReg <= magA;
                hiReg      <= '0;
                loReg      <= (magA == '0) ? '0 : magB;
                negResult  <= signA ^ signB;
            end
        end else if (step && !holdReg) begin
            hiReg <= hiNext;
            loReg <= loNext;
        end
    end

    // Sign fix-up and result selection.
    always_comb begin
        product    = {hiReg, loReg};
        productFix = negResult ? (~product + (2*XLEN)'(1)) : product;
        divRaw     = opReg[1] ? hiReg : loReg;
        result_c   = productFix[2*XLEN-1:XLEN];
        if (is_div(opReg)) begin
            result_c = negResult ? (~divRaw + XLEN'(1)) : divRaw;
        end else if (opReg == OP_MUL) begin
            result_c = productFix[XLEN-1:0];
        end
    end

endmodule

// File: rtl/muldiv_controller.sv
// muldiv_controller: iterative RV32M multiply/divide sequencer beside the Execute ALU.
// Optional MULDIV_FAST_ZERO_EN: zero-operand ops skip straight from IDLE to DONE.
module muldiv_controller
    import muldiv_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        StartE,
    input  logic [2:0]  OpE,
    input  logic [31:0] Src_A,
    input  logic [31:0] Src_B,
    input  logic [4:0]  RD_E,
    input  logic        FlushE,
    output logic        BusyE,
    output logic        DoneE,
    output logic [31:0] ResultE,
    output logic [4:0]  RD_Out
);

    mdState_t         state;
    mdState_t         nextState;
    logic [CNT_W-1:0] count;
    logic             accept;
    logic             load;
    logic             step;
    logic             fastZero;
    logic [XLEN-1:0]  dpResult;
    logic [XLEN-1:0]  resultHold;
    logic [RD_W-1:0]  rdLatch;
    logic [RD_W-1:0]  rdHold;

    assign accept = (state == IDLE) & StartE & ~FlushE;

`ifdef MULDIV_FAST_ZERO_EN
    assign fastZero = is_div(OpE) ? (Src_B == '0) : ((Src_A == '0) || (Src_B == '0));
`else
    assign fastZero = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    nextState = fastZero ? DONE : RUN;
                end
            end
            RUN: begin
                if (FlushE) begin
                    nextState = IDLE;
                end else if (count == '0) begin
                    nextState = DONE;
                end
            end
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Busy covers the accept cycle; result and rd are presented live in DONE, held after.
    always_comb begin
        BusyE   = accept | (state == RUN);
        DoneE   = 1'b0;
        ResultE = resultHold;
        RD_Out  = rdHold;
        load    = accept;
        step    = (state == RUN);
        if (state == DONE) begin
            DoneE   = ~FlushE;
            ResultE = dpResult;
            RD_Out  = rdLatch;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count      <= '0;
            rdLatch    <= '0;
            resultHold <= '0;
            rdHold     <= '0;
        end else begin
            if (accept) begin
                count   <= CNT_W'(ITER_LAST);
                rdLatch <= RD_E;
            end else if (step && (count != '0)) begin
                count <= count - CNT_W'(1);
            end
            if (state == DONE) begin
                resultHold <= dpResult;
                rdHold     <= rdLatch;
            end
        end
    end

    muldiv_datapath u_datapath (
        .clock    (clock),
        .reset    (reset),
        .load     (load),
        .step     (step),
        .op       (OpE),
        .srcA     (Src_A),
        .srcB     (Src_B),
        .result_c (dpResult)
    );

endmodule

// File: tb/tb_muldiv_controller.sv
// tb_muldiv_controller: directed and random RV32M ops checked every cycle against
// an arithmetic reference model, plus literal result pins from hand-worked cases.
module tb_muldiv_controller;
    import muldiv_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        StartE;
    logic [2:0]  OpE;
    logic [31:0] Src_A;
    logic [31:0] Src_B;
    logic [4:0]  RD_E;
    logic        FlushE;
    logic        BusyE;
    logic        DoneE;
    logic [31:0] ResultE;
    logic [4:0]  RD_Out;

    int          checks = 0;
    int          errors = 0;
    logic        checkEn;
    logic        expBusy;
    logic        expDone;
    logic [31:0] expResult;
    logic [4:0]  expRd;

    always #5 clock = ~clock;

    muldiv_controller dut (
        .clock   (clock),
        .reset   (reset),
        .StartE  (StartE),
        .OpE     (OpE),
        .Src_A   (Src_A),
        .Src_B   (Src_B),
        .RD_E    (RD_E),
        .FlushE  (FlushE),
        .BusyE   (BusyE),
        .DoneE   (DoneE),
        .ResultE (ResultE),
        .RD_Out  (RD_Out)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t actual=%h expected=%h", name, $time, act, exp);
        end
    endtask

    // Architectural RV32M result computed with wide integer arithmetic.
    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        longint          p;
        longint unsigned up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = 64'(a);
        ub = 64'(b);
        case (op)
            3'b000: begin p = sa * sb; return p[31:0]; end
            3'b001: begin p = sa * sb; return p[63:32]; end
            3'b010: begin p = sa * longint'(ub); return p[63:32]; end
            3'b011: begin up = ua * ub; return up[63:32]; end
            3'b100: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = sa / sb; return p[31:0];
            end
            3'b101: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'b110: begin
                if (b == 32'd0) return a;
                p = sa % sb; return p[31:0];
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    // Cycle index of DONE relative to the accept cycle.
    function automatic int latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_FAST_ZERO_EN
        if (op[2] ? (b == 32'd0) : ((a == 32'd0) || (b == 32'd0))) return 1;
`endif
        return 33;
    endfunction

    always @(negedge clock) begin
        if (checkEn) begin
            check("BusyE", 32'(BusyE), 32'(expBusy));
            check("DoneE", 32'(DoneE), 32'(expDone));
            check("ResultE", ResultE, expResult);
            check("RD_Out", 32'(RD_Out), 32'(expRd));
        end
    end

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    // flushAt: -1 none, 0 flush on the accept cycle, k flush in cycle k after accept.
    task automatic runOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input int flushAt);
        int          lat;
        logic [31:0] r;
        lat    = latency(op, a, b);
        r      = model(op, a, b);
        StartE = 1'b1;
        OpE    = op;
        Src_A  = a;
        Src_B  = b;
        RD_E   = rd;
        FlushE = (flushAt == 0);
        expBusy = (flushAt != 0);
        expDone = 1'b0;
        if (flushAt != 0) begin
            for (int k = 1; k <= lat; k++) begin
                cycle();
                FlushE  = (k == flushAt);
                expBusy = (k < lat);
                expDone = (k == lat) && (k != flushAt);
                if (k == lat) begin
                    expResult = r;
                    expRd     = rd;
                end
                if ((k == flushAt) && (k < lat)) break;
            end
        end
        cycle();
        StartE  = 1'b0;
        FlushE  = 1'b0;
        expBusy = 1'b0;
        expDone = 1'b0;
    endtask

    task automatic lit(input string name, input logic [31:0] exp);
        #2;
        check(name, ResultE, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; StartE = 1'b0; FlushE = 1'b0; OpE = '0;
        Src_A = '0; Src_B = '0; RD_E = '0;
        checkEn = 1'b0; expBusy = 1'b0; expDone = 1'b0; expResult = '0; expRd = '0;
        repeat (2) @(posedge clock);
        #1;
        reset   = 1'b0;
        checkEn = 1'b1;
        #2;
        check("rst ResultE", ResultE, 32'h0);
        check("rst RD_Out", 32'(RD_Out), 32'h0);
        check("rst BusyE", 32'(BusyE), 32'h0);

        runOp(OP_MUL, 32'd7, 32'hFFFF_FFFD, 5'd1, -1);         lit("MUL 7*-3", 32'hFFFF_FFEB);
        runOp(OP_MULH, 32'h8000_0000, 32'h8000_0000, 5'd2, -1); lit("MULH min*min", 32'h4000_0000);
        runOp(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, -1); lit("MULHU max*max", 32'hFFFF_FFFE);
        runOp(OP_MULHSU, 32'hFFFF_FFFF, 32'd2, 5'd4, -1);       lit("MULHSU -1*2", 32'hFFFF_FFFF);
        runOp(OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd5, -1);          lit("DIV -7/2", 32'hFFFF_FFFD);
        runOp(OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd6, -1);          lit("REM -7/2", 32'hFFFF_FFFF);
        runOp(OP_DIVU, 32'd5, 32'd0, 5'd7, -1);                 lit("DIVU 5/0", 32'hFFFF_FFFF);
        runOp(OP_REM, 32'd5, 32'd0, 5'd8, -1);                  lit("REM 5/0", 32'd5);
        runOp(OP_REM, 32'hFFFF_FFFB, 32'd0, 5'd9, -1);          lit("REM -5/0", 32'hFFFF_FFFB);
        runOp(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, -1); lit("DIV ovf", 32'h8000_0000);
        runOp(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, -1); lit("REM ovf", 32'h0);

        // Abort in RUN, then a new op accepted on the very next cycle.
        runOp(OP_DIVU, 32'd1000, 32'd3, 5'd12, 10);
        runOp(OP_REMU, 32'd100, 32'd7, 5'd13, -1);             lit("REMU after flush", 32'd2);
        check("RD_Out after flush", 32'(RD_Out), 32'd13);

        runOp(OP_MUL, 32'd3, 32'd4, 5'd14, 0);
        runOp(OP_MULHU, 32'h1234_5678, 32'h9ABC_DEF0, 5'd15, 33);
        runOp(OP_MUL, 32'd0, 32'd123, 5'd16, -1);              lit("MUL 0*123", 32'h0);
        runOp(OP_DIVU, 32'd77, 32'd0, 5'd17, -1);

        // Synchronous reset in the middle of RUN discards the op.
        StartE = 1'b1; OpE = OP_DIV; Src_A = 32'd100; Src_B = 32'd3; RD_E = 5'd18;
        expBusy = 1'b1; expDone = 1'b0;
        for (int k = 0; k < 5; k++) cycle();
        checkEn = 1'b0;
        reset   = 1'b1;
        cycle();
        reset = 1'b0; StartE = 1'b0;
        expBusy = 1'b0; expResult = '0; expRd = '0;
        checkEn = 1'b1;
        #2;
        check("midrun rst ResultE", ResultE, 32'h0);
        check("midrun rst RD_Out", 32'(RD_Out), 32'h0);
        check("midrun rst BusyE", 32'(BusyE), 32'h0);
        check("midrun rst DoneE", 32'(DoneE), 32'h0);

        for (int i = 0; i < 8; i++) begin
            runOp(3'($urandom_range(0, 7)), $urandom,
                  (i % 3 == 0) ? 32'($urandom_range(1, 9)) : $urandom, 5'(i + 20), -1);
        end
        cycle();
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
